regfile_wb_arbiter: RTL and testbench

Writeback controller for the 32x32 register file. It shares the file's single write port between two writeback sources: A (ALU result) and B (memory/load result). It uses round-robin arbitration and a registered write stage. It also keeps a pending-write scoreboard so decode can detect read-after-write hazards on registers with a write still in flight.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/wb_rr_arbiter.sv | 23 ++
 rtl/regfile_wb_arbiter.sv | 78 +++++++
 tb/tb_regfile_wb_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes and grant encoding for the register-file writeback path
package regfile_pkg;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] ZERO_REG = '0;
  typedef enum logic {GRANT_A, GRANT_B} grant_t;
endpackage

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: two-source round-robin grant with last-grant memory
module wb_rr_arbiter
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a_valid_i,
  input  logic b_valid_i,
  input  logic stall_i,
  output logic a_gnt_o,
  output logic b_gnt_o
);
  grant_t last_q, last_d;
  always_comb begin
    a_gnt_o = !reset && !stall_i && a_valid_i && (!b_valid_i || last_q == GRANT_B);
    b_gnt_o = !reset && !stall_i && b_valid_i && (!a_valid_i || last_q == GRANT_A);
    last_d = a_gnt_o ? GRANT_A : b_gnt_o ? GRANT_B : last_q;
  end
  always_ff @(posedge clk) begin
    if (reset) last_q <= GRANT_B;
    else last_q <= last_d;
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between two writeback
// sources and tracks in-flight destination registers for hazard detection
module regfile_wb_arbiter #(
  parameter int NUM_REGS = regfile_pkg::NUM_REGS,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int DATA_W = regfile_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                AValid,
  input  logic [ADDR_W-1:0]   AReg,
  input  logic [DATA_W-1:0]   AData,
  output logic                AReady,
  input  logic                BValid,
  input  logic [ADDR_W-1:0]   BReg,
  input  logic [DATA_W-1:0]   BData,
  output logic                BReady,
  input  logic                WbStall,
  input  logic                Reserve,
  input  logic [ADDR_W-1:0]   ReserveReg,
  input  logic [ADDR_W-1:0]   QueryReg1,
  input  logic [ADDR_W-1:0]   QueryReg2,
  output logic                Busy1,
  output logic                Busy2,
  output logic [NUM_REGS-1:0] Pending,
  output logic                RegWrite,
  output logic [ADDR_W-1:0]   WriteReg,
  output logic [DATA_W-1:0]   WriteData
);
  import regfile_pkg::*;
  logic a_rdy, b_rdy, reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] sel_reg, write_reg_q, write_reg_d;
  logic [DATA_W-1:0] sel_data, write_data_q, write_data_d;
  logic [NUM_REGS-1:0] pending_q, pending_d;
  wb_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .a_valid_i (AValid),
    .b_valid_i (BValid),
    .stall_i   (WbStall),
    .a_gnt_o   (a_rdy),
    .b_gnt_o   (b_rdy)
  );
  // Register-0 transfers are consumed but never reach the file, so the write
  // stage keeps its last index/data for them just as on an idle cycle.
  always_comb begin
    sel_reg = a_rdy ? AReg : BReg;
    sel_data = a_rdy ? AData : BData;
    reg_write_d = (a_rdy || b_rdy) && sel_reg != ADDR_W'(ZERO_REG);
    write_reg_d = reg_write_d ? sel_reg : write_reg_q;
    write_data_d = reg_write_d ? sel_data : write_data_q;
    pending_d = pending_q;
    if (reg_write_q) pending_d[write_reg_q] = 1'b0;
    if (Reserve) pending_d[ReserveReg] = 1'b1;
    pending_d[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q <= 1'b0;
      write_reg_q <= '0;
      write_data_q <= '0;
      pending_q <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      write_reg_q <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q <= pending_d;
    end
  end
  assign AReady = a_rdy;
  assign BReady = b_rdy;
  assign Busy1 = pending_q[QueryReg1];
  assign Busy2 = pending_q[QueryReg2];
  assign Pending = pending_q;
  assign RegWrite = reg_write_q;
  assign WriteReg = write_reg_q;
  assign WriteData = write_data_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks against a behavioural writeback model
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1, AValid = 1'b0, BValid = 1'b0, WbStall = 1'b0, Reserve = 1'b0;
  logic [4:0] AReg = '0, BReg = '0, ReserveReg = '0, QueryReg1 = '0, QueryReg2 = '0;
  logic [31:0] AData = '0, BData = '0;
  logic AReady, BReady, Busy1, Busy2, RegWrite;
  logic [31:0] Pending, WriteData;
  logic [4:0] WriteReg;
  regfile_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .AValid(AValid), .AReg(AReg), .AData(AData), .AReady(AReady),
    .BValid(BValid), .BReg(BReg), .BData(BData), .BReady(BReady),
    .WbStall(WbStall), .Reserve(Reserve), .ReserveReg(ReserveReg),
    .QueryReg1(QueryReg1), .QueryReg2(QueryReg2), .Busy1(Busy1), .Busy2(Busy2),
    .Pending(Pending), .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
  );
  int n_checks = 0, n_fail = 0;
  int commits[$];
  // behavioural model state: who won last, pending set, write-stage contents
  logic m_last_b = 1'b1;
  logic [31:0] m_pend = '0;
  logic m_rw = 1'b0;
  logic [4:0] m_wr = '0;
  logic [31:0] m_wd = '0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [1:0] gnt();
    if (reset || WbStall) return 2'b00;
    if (AValid && BValid) return m_last_b ? 2'b01 : 2'b10;
    return {BValid, AValid};
  endfunction
  always @(posedge clk) begin
    logic [1:0] g;
    logic [4:0] r;
    g = gnt();
    if (reset) begin
      m_last_b = 1'b1; m_pend = '0; m_rw = 1'b0; m_wr = '0; m_wd = '0;
    end else begin
      if (m_rw) m_pend[m_wr] = 1'b0;
      if (Reserve && ReserveReg != 0) m_pend[ReserveReg] = 1'b1;
      r = g[0] ? AReg : BReg;
      m_rw = (g != 0) && r != 0;
      if (m_rw) begin
        m_wr = r;
        m_wd = g[0] ? AData : BData;
      end
      if (g != 0) m_last_b = g[1];
    end
  end
  always @(negedge clk) begin
    logic [1:0] g;
    g = gnt();
    chk("a_ready", AReady, g[0]);
    chk("b_ready", BReady, g[1]);
    chk("reg_write", RegWrite, m_rw);
    chk("write_reg", WriteReg, m_wr);
    chk("write_data", WriteData, m_wd);
    chk("pending", Pending, m_pend);
    chk("busy1", Busy1, m_pend[QueryReg1]);
    chk("busy2", Busy2, m_pend[QueryReg2]);
    if (RegWrite === 1'b1) commits.push_back(int'(WriteReg));
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int ai, bi;
    logic a_stuck, b_stuck;
    reset = 1'b1; AValid = 1'b1; AReg = 5'd3; AData = 32'h11;
    #2 chk("rst_aready", AReady, 0);
    tick(); tick();
    chk("rst_regwrite", RegWrite, 0);
    chk("rst_pending", Pending, 0);
    reset = 1'b0;
    AReg = 5'd5; AData = 32'hDEADBEEF; BValid = 1'b1; BReg = 5'd6; BData = 32'h66;
    #2 chk("first_a", AReady, 1);
    chk("first_b_wait", BReady, 0);
    tick();
    AValid = 1'b0;
    #2 chk("b_next", BReady, 1);
    chk("single_rw", RegWrite, 1);
    chk("single_reg", WriteReg, 5);
    chk("single_data", WriteData, 32'hDEADBEEF);
    tick();
    BValid = 1'b0;
    #2 chk("b_reg", WriteReg, 6);
    tick();
    chk("idle_rw", RegWrite, 0);
    chk("idle_hold", WriteReg, 6);
    commits.delete();
    ai = 0; bi = 0;
    AValid = 1'b1; BValid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      AReg = 5'(1 + ai); AData = 32'hA0 + 32'(ai);
      BReg = 5'(9 + bi); BData = 32'hB0 + 32'(bi);
      #2;
      if (AReady) ai++;
      if (BReady) bi++;
      tick();
    end
    AValid = 1'b0; BValid = 1'b0;
    tick(); tick();
    chk("cont_a_count", ai, 2);
    chk("cont_b_count", bi, 2);
    chk("cont_ncommit", commits.size(), 4);
    if (commits.size() == 4) begin
      chk("order0", commits[0], 1);
      chk("order1", commits[1], 9);
      chk("order2", commits[2], 2);
      chk("order3", commits[3], 10);
    end
    WbStall = 1'b1; AValid = 1'b1; BValid = 1'b1; AReg = 5'd3; BReg = 5'd4;
    #2 chk("stall_a", AReady, 0);
    chk("stall_b", BReady, 0);
    tick();
    WbStall = 1'b0; BValid = 1'b0; AReg = 5'd0; AData = 32'h5A5A;
    #2 chk("stall_rw", RegWrite, 0);
    chk("r0_ready", AReady, 1);
    tick();
    AValid = 1'b0;
    #2 chk("r0_rw", RegWrite, 0);
    Reserve = 1'b1; ReserveReg = 5'd7;
    tick();
    Reserve = 1'b0; QueryReg1 = 5'd7; QueryReg2 = 5'd8;
    #2 chk("busy1_7", Busy1, 1);
    chk("busy2_8", Busy2, 0);
    BValid = 1'b1; BReg = 5'd7; BData = 32'h77;
    #1 chk("sb_bready", BReady, 1);
    tick();
    BValid = 1'b0; Reserve = 1'b1; ReserveReg = 5'd7;
    #2 chk("sb_rw", RegWrite, 1);
    chk("sb_pend_inflight", Pending[7], 1);
    tick();
    Reserve = 1'b0;
    #2 chk("set_wins", Pending[7], 1);
    BValid = 1'b1;
    tick();
    BValid = 1'b0;
    tick();
    chk("clear_7", Pending[7], 0);
    Reserve = 1'b1; ReserveReg = 5'd0;
    tick();
    Reserve = 1'b0;
    chk("r0_reserve", Pending, 0);
    AValid = 1'b1; AReg = 5'd3; AData = 32'h33; Reserve = 1'b1; ReserveReg = 5'd3;
    tick();
    AValid = 1'b0; Reserve = 1'b0; reset = 1'b1;
    #2 chk("mid_rw_inflight", RegWrite, 1);
    chk("mid_pend3", Pending[3], 1);
    tick();
    chk("mid_rst_rw", RegWrite, 0);
    chk("mid_rst_pend", Pending, 0);
    reset = 1'b0;
    tick();
    chk("mid_no_commit", RegWrite, 0);
    a_stuck = 1'b0; b_stuck = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!a_stuck) begin
        AValid = ($urandom_range(0, 3) != 0);
        AReg = 5'($urandom_range(0, 31)); AData = $urandom;
      end
      if (!b_stuck) begin
        BValid = ($urandom_range(0, 3) != 0);
        BReg = 5'($urandom_range(0, 31)); BData = $urandom;
      end
      WbStall = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 99) == 0);
      Reserve = ($urandom_range(0, 1) == 1);
      ReserveReg = 5'($urandom_range(0, 31));
      QueryReg1 = 5'($urandom_range(0, 31));
      QueryReg2 = 5'($urandom_range(0, 31));
      #2;
      a_stuck = AValid && !AReady;
      b_stuck = BValid && !BReady;
      tick();
    end
    reset = 1'b0; AValid = 1'b0; BValid = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
